frame_buf_arbiter: RTL and testbench

FRAME_BUF_ARBITER -- requirements
Module: frame_buf_arbiter

---
 rtl/frame_buf_pkg.sv | 24 ++
 rtl/frame_buf_wr_fifo.sv | 60 ++++++
 rtl/frame_buf_arbiter.sv | 153 +++++++++++++++
 tb/tb_frame_buf_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_buf_pkg.sv
// Shared types and widths for the frame buffer arbiter.
// Holds FSM encoding, address/pixel widths and the write FIFO entry.
package frame_buf_pkg;

    localparam int ADR_W    = 15;
    localparam int PIX_W    = 16;
    localparam int BANK_BIT = 15;
    localparam int RAM_AW   = BANK_BIT + 1;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RD_CAP,
        RD_HOLD
    } state_t;

    typedef struct packed {
        logic             bank;
        logic [ADR_W-1:0] adr;
        logic [PIX_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/frame_buf_wr_fifo.sv
// Video write FIFO; each entry carries the bank it was tagged with.
// A push while full is accepted only if a pop frees a slot that cycle.
import frame_buf_pkg::*;

module frame_buf_wr_fifo #(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  wr_entry_t     din,
    output wr_entry_t     dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    wr_entry_t      mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/frame_buf_arbiter.sv
// Arbitrates a double-banked frame RAM between queued video writes
// and host reads, with bank swap and frame-ready interrupts.
import frame_buf_pkg::*;

module frame_buf_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int IRQ_LEN    = 2
) (
    input  logic              Sys_clk,
    input  logic              resetx,
    input  logic              vid_wr_stb,
    input  logic [ADR_W-1:0]  vid_adr,
    input  logic [PIX_W-1:0]  vid_data,
    input  logic              vid_frame_end,
    input  logic              host_csx,
    input  logic              host_rdx,
    input  logic [ADR_W-1:0]  host_adr,
    output logic [PIX_W-1:0]  host_rdata,
    output logic              host_waitx,
    output logic              host_irq0,
    output logic              host_irq1,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [PIX_W-1:0]  ram_wdata,
    output logic              ram_wren,
    output logic              ram_rden,
    input  logic [PIX_W-1:0]  ram_q,
    output logic              fifo_ovf
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int IW = $clog2(IRQ_LEN + 1);

    state_t         state;
    state_t         state_nx;
    wr_entry_t      din;
    wr_entry_t      head;
    logic           full;
    logic           empty;
    logic [CW-1:0]  count;
    logic           pop;
    logic           wr_bank;
    logic           rd_bank;
    logic           rd_done;
    logic           pending;
    logic           released;
    logic           room;
    logic [IW-1:0]  irq_cnt;

    assign din        = {wr_bank, vid_adr, vid_data};
    assign released   = host_csx || host_rdx;
    assign pending    = !released && !rd_done;
    assign room       = count < CW'(FIFO_DEPTH - 1);
    assign pop        = (state_nx == WR);
    assign host_waitx = !(pending && state != RD_HOLD);

    frame_buf_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (Sys_clk),
        .rst_n (resetx),
        .push  (vid_wr_stb),
        .pop   (pop),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, WR: begin
                if (pending && room) begin
                    state_nx = RD;
                end else if (!empty) begin
                    state_nx = WR;
                end else begin
                    state_nx = IDLE;
                end
            end
            RD:      state_nx = released ? IDLE : RD_CAP;
            RD_CAP:  state_nx = released ? IDLE : RD_HOLD;
            RD_HOLD: state_nx = released ? IDLE : RD_HOLD;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Sys_clk or negedge resetx) begin
        if (!resetx) begin
            state      <= IDLE;
            rd_done    <= 1'b0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b1;
            fifo_ovf   <= 1'b0;
            host_rdata <= '0;
        end else begin
            state <= state_nx;
            if (released) begin
                rd_done <= 1'b0;
            end else if (state == RD_CAP) begin
                rd_done <= 1'b1;
            end
            if (vid_frame_end) begin
                rd_bank <= wr_bank;
                wr_bank <= ~wr_bank;
            end
            if (vid_wr_stb && full && !pop) begin
                fifo_ovf <= 1'b1;
            end
            if (state == RD_CAP) begin
                host_rdata <= ram_q;
            end
        end
    end

    // RAM strobes are registered from the next-state decision.
    always_ff @(posedge Sys_clk or negedge resetx) begin
        if (!resetx) begin
            ram_wren  <= 1'b0;
            ram_rden  <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            ram_wren <= (state_nx == WR);
            ram_rden <= (state_nx == RD);
            if (state_nx == WR) begin
                ram_addr  <= {head.bank, head.adr};
                ram_wdata <= head.data;
            end else if (state_nx == RD) begin
                ram_addr <= {rd_bank, host_adr};
            end
        end
    end

    always_ff @(posedge Sys_clk or negedge resetx) begin
        if (!resetx) begin
            irq_cnt   <= '0;
            host_irq0 <= 1'b0;
            host_irq1 <= 1'b0;
        end else if (vid_frame_end) begin
            irq_cnt   <= IW'(IRQ_LEN - 1);
            host_irq0 <= wr_bank;
            host_irq1 <= ~wr_bank;
        end else if (irq_cnt != '0) begin
            irq_cnt <= irq_cnt - IW'(1);
        end else begin
            host_irq0 <= 1'b0;
            host_irq1 <= 1'b0;
        end
    end

endmodule

// File: tb/tb_frame_buf_arbiter.sv
// Scoreboard bench for frame_buf_arbiter with a simple frame RAM model.
// Directed vectors push expected RAM/host events; a monitor checks them.
module tb_frame_buf_arbiter;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } wexp_t;

    logic        clk = 1'b0;
    logic        resetx = 1'b0;
    logic        vid_wr_stb = 1'b0;
    logic [14:0] vid_adr = '0;
    logic [15:0] vid_data = '0;
    logic        vid_frame_end = 1'b0;
    logic        host_csx = 1'b1;
    logic        host_rdx = 1'b1;
    logic [14:0] host_adr = '0;
    logic [15:0] host_rdata;
    logic        host_waitx;
    logic        host_irq0;
    logic        host_irq1;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_wren;
    logic        ram_rden;
    logic [15:0] ram_q = '0;
    logic        fifo_ovf;

    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [15:0] pl_data = '0;
    logic [15:0] mem [65536];

    wexp_t       wq [$];
    logic [15:0] rq [$];
    logic [15:0] dq [$];
    wexp_t       wcur;
    logic [15:0] rcur;
    bit          prev_waitx;
    int          irq0_n = 0;
    int          irq1_n = 0;
    int          ncmp = 0;
    int          nerr = 0;
    int          c0;
    int          c1;

    always #5 clk = ~clk;

    frame_buf_arbiter #(
        .FIFO_DEPTH (4),
        .IRQ_LEN    (2)
    ) dut (
        .Sys_clk       (clk),
        .resetx        (resetx),
        .vid_wr_stb    (vid_wr_stb),
        .vid_adr       (vid_adr),
        .vid_data      (vid_data),
        .vid_frame_end (vid_frame_end),
        .host_csx      (host_csx),
        .host_rdx      (host_rdx),
        .host_adr      (host_adr),
        .host_rdata    (host_rdata),
        .host_waitx    (host_waitx),
        .host_irq0     (host_irq0),
        .host_irq1     (host_irq1),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_wren      (ram_wren),
        .ram_rden      (ram_rden),
        .ram_q         (ram_q),
        .fifo_ovf      (fifo_ovf)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Frame RAM: one-cycle read latency.
    initial forever begin
        @(posedge clk);
        if (pl_en) mem[pl_addr] = pl_data;
        if (ram_wren) mem[ram_addr] = ram_wdata;
        if (ram_rden) ram_q <= mem[ram_addr];
    end

    // Monitor.
    initial forever begin
        @(negedge clk);
        if (resetx) begin
            if (ram_wren && ram_rden) check("wren_rden_excl", 1, 0);
            if (ram_wren) begin
                if (wq.size() == 0) begin
                    check("unexpected_wr", {16'h0, ram_addr}, 32'hffff_ffff);
                end else begin
                    wcur = wq.pop_front();
                    check("wr_addr", ram_addr, wcur.a);
                    check("wr_data", ram_wdata, wcur.d);
                end
            end
            if (ram_rden) begin
                if (rq.size() == 0) begin
                    check("unexpected_rd", {16'h0, ram_addr}, 32'hffff_ffff);
                end else begin
                    rcur = rq.pop_front();
                    check("rd_addr", ram_addr, rcur);
                end
            end
            if (!host_csx && !host_rdx && !prev_waitx && host_waitx) begin
                if (dq.size() == 0) begin
                    check("unexpected_rdata", host_rdata, 32'hffff_ffff);
                end else begin
                    rcur = dq.pop_front();
                    check("host_rdata", host_rdata, rcur);
                end
            end
            if (host_irq0) irq0_n++;
            if (host_irq1) irq1_n++;
        end
        prev_waitx = host_waitx;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        step();
        pl_en = 1'b1;
        pl_addr = a;
        pl_data = d;
        step();
        pl_en = 1'b0;
    endtask

    task automatic vid_push(input logic [14:0] a, input logic [15:0] d,
                            input logic [15:0] ea, input bit expect_wr);
        step();
        vid_wr_stb = 1'b1;
        vid_adr = a;
        vid_data = d;
        if (expect_wr) wq.push_back('{ea, d});
    endtask

    task automatic vid_stop();
        step();
        vid_wr_stb = 1'b0;
    endtask

    task automatic frame_end(input int n);
        step();
        vid_frame_end = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        vid_frame_end = 1'b0;
    endtask

    task automatic host_release();
        step();
        host_csx = 1'b1;
        host_rdx = 1'b1;
    endtask

    task automatic host_read(input logic [14:0] a, input logic [15:0] exp,
                             input logic bank, input int exp_wait,
                             input bit hold);
        int w;
        bit done;
        rq.push_back({bank, a});
        dq.push_back(exp);
        step();
        host_csx = 1'b0;
        host_rdx = 1'b0;
        host_adr = a;
        w = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (host_waitx) done = 1'b1;
            else w++;
        end
        if (!done) check("read_timeout", 0, 1);
        else if (exp_wait >= 0) check("wait_cycles", w, exp_wait);
        if (!hold) host_release();
    endtask

    initial begin
        preload(16'h8005, 16'hABCD);
        preload(16'h8010, 16'h1234);
        preload(16'h8011, 16'h5678);
        preload(16'h8012, 16'h9ABC);
        preload(16'h0007, 16'h2222);
        preload(16'h8003, 16'h3333);
        @(negedge clk);
        check("rst_wren", ram_wren, 0);
        check("rst_rden", ram_rden, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_wdata", ram_wdata, 0);
        check("rst_rdata", host_rdata, 0);
        check("rst_irq", {host_irq0, host_irq1}, 0);
        check("rst_ovf", fifo_ovf, 0);
        check("rst_waitx", host_waitx, 1);
        step();
        resetx = 1'b1;
        repeat (2) step();

        // Three back-to-back pixel writes to bank 0.
        vid_push(15'd0, 16'hF800, 16'h0000, 1'b1);
        vid_push(15'd1, 16'h07E0, 16'h0001, 1'b1);
        vid_push(15'd2, 16'h001F, 16'h0002, 1'b1);
        vid_stop();
        repeat (6) step();

        // Plain host read from bank 1.
        host_read(15'd5, 16'hABCD, 1'b1, 3, 1'b0);
        repeat (4) step();

        // Three writes queue behind a held read; next read waits for one.
        host_read(15'h10, 16'h1234, 1'b1, 3, 1'b1);
        for (int i = 0; i < 3; i++)
            vid_push(15'h20 + 15'(i), 16'h0A00 + 16'(i), 16'h0020 + 16'(i), 1'b1);
        vid_stop();
        host_release();
        host_read(15'h11, 16'h5678, 1'b1, 4, 1'b0);
        repeat (6) step();
        @(negedge clk);
        check("ovf_clear", fifo_ovf, 0);

        // Five pushes into a 4-deep FIFO while the RAM is held.
        host_read(15'h12, 16'h9ABC, 1'b1, 3, 1'b1);
        for (int i = 0; i < 5; i++)
            vid_push(15'h30 + 15'(i), 16'h0C00 + 16'(i), 16'h0030 + 16'(i), i < 4);
        vid_stop();
        host_release();
        repeat (8) step();
        @(negedge clk);
        check("ovf_set", fifo_ovf, 1);

        // Bank swap from wr_bank 0.
        c0 = irq0_n;
        c1 = irq1_n;
        frame_end(1);
        repeat (5) step();
        check("irq1_len", irq1_n - c1, 2);
        check("irq0_quiet", irq0_n - c0, 0);
        vid_push(15'd7, 16'h1111, 16'h8007, 1'b1);
        vid_stop();
        repeat (4) step();
        host_read(15'd7, 16'h2222, 1'b0, 3, 1'b1);
        // Queued entry keeps its bank across a swap.
        c0 = irq0_n;
        c1 = irq1_n;
        vid_push(15'h40, 16'hAAAA, 16'h8040, 1'b1);
        vid_stop();
        frame_end(1);
        vid_push(15'h41, 16'hBBBB, 16'h0041, 1'b1);
        vid_stop();
        host_release();
        repeat (6) step();
        check("irq0_len", irq0_n - c0, 2);
        check("irq1_quiet2", irq1_n - c1, 0);

        // Back-to-back frame ends restart the pulse on the other line.
        c0 = irq0_n;
        c1 = irq1_n;
        frame_end(2);
        repeat (6) step();
        check("irq1_cut", irq1_n - c1, 1);
        check("irq0_restart", irq0_n - c0, 2);

        // Reset while writing with entries still queued.
        host_read(15'd3, 16'h3333, 1'b1, 3, 1'b1);
        for (int i = 0; i < 3; i++)
            vid_push(15'h50 + 15'(i), 16'h0E00 + 16'(i), 16'h0, 1'b0);
        vid_stop();
        host_release();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("in_wr", ram_wren, 1);
        resetx = 1'b0;
        #1;
        check("mid_rst_wren", ram_wren, 0);
        check("mid_rst_addr", ram_addr, 0);
        check("mid_rst_wdata", ram_wdata, 0);
        check("mid_rst_rdata", host_rdata, 0);
        check("mid_rst_ovf", fifo_ovf, 0);
        @(negedge clk);
        resetx = 1'b1;
        repeat (10) step();

        check("wq_drained", wq.size(), 0);
        check("rq_drained", rq.size(), 0);
        check("dq_drained", dq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
